// File: rtl/pic_gpio_pkg.sv
// pic_gpio_pkg: shared constants for the GPIO input conditioner.
// This package holds the register address map and the width of the
// per-bit debounce counter.
package pic_gpio_pkg;

  localparam logic [1:0] PIC_GPIO_REG_FILT    = 2'd0;
  localparam logic [1:0] PIC_GPIO_REG_STATUS  = 2'd1;
  localparam logic [1:0] PIC_GPIO_REG_RISE_EN = 2'd2;
  localparam logic [1:0] PIC_GPIO_REG_FALL_EN = 2'd3;

  // The per-bit debounce counter must be able to hold DEB_TICKS values up to 15.
  localparam int PIC_GPIO_CNT_W = 4;

endpackage

// File: rtl/pic_gpio_sync2.sv
// pic_gpio_sync2: two-flop synchroniser for a bus of independent raw inputs.
// Each bit is synchronised on its own, with no coherence between bits.
module pic_gpio_sync2 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] sync
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture. The first stage may go metastable; the second stage gives it a cycle to resolve.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      // NOTE: non-blocking assignments keep this a two-flop shift chain; blocking would collapse it to one flop.
      meta <= raw;
      sync <= meta;
    end
  end

endmodule

// File: rtl/pic_gpio_cond.sv
// pic_gpio_cond: GPIO input conditioner.
// This block synchronises the pins, optionally debounces them, and detects edges into a W1C status register with a level irq.
// Defining PIC_GPIO_COND_DEBOUNCE_EN builds the prescaler and the per-bit debounce counters.
// Without that macro, gpio_filt follows the synchronised pins with one register of delay.
module pic_gpio_cond
  import pic_gpio_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int PRESCALE  = 1000,
  parameter int DEB_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] gpio_filt,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wen,
  input  logic             ren,
  output logic [WIDTH-1:0] rdata,
  output logic             ready,
  output logic             irq
);

  // Elaboration-time range checks on the parameters.
  if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
    $error("pic_gpio_cond: PRESCALE out of range 2..65535");
  end
  if (DEB_TICKS < 1 || DEB_TICKS > 15) begin : g_bad_deb_ticks
    $error("pic_gpio_cond: DEB_TICKS out of range 1..15");
  end

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt_q;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] reg_val;

  pic_gpio_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (pin_in),
    .sync    (sync)
  );

`ifdef PIC_GPIO_COND_DEBOUNCE_EN
  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0]          PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PIC_GPIO_CNT_W-1:0] DEB_LIM  = PIC_GPIO_CNT_W'(DEB_TICKS);

  logic [PRE_W-1:0]                     presc;
  logic                                 tick;
  logic [WIDTH-1:0][PIC_GPIO_CNT_W-1:0] cnt;

  assign tick = (presc == PRE_LAST);

  // Shared prescaler. It counts 0..PRESCALE-1, and tick is high during the last count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PRE_W'(1);
  end

  // Per-bit debounce. A bit must disagree with gpio_filt for DEB_TICKS ticks in a row before it is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the counter array is ordinary state, so it is reset; a reset clears any debounce count in progress.
      cnt       <= '0;
      gpio_filt <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == gpio_filt[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] + PIC_GPIO_CNT_W'(1) == DEB_LIM) begin
            gpio_filt[i] <= sync[i];
            cnt[i]       <= '0;
          end else begin
            cnt[i] <= cnt[i] + PIC_GPIO_CNT_W'(1);
          end
        end
      end
    end
  end
`else
  // No debounce: one register stage after the synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) gpio_filt <= '0;
    else          gpio_filt <= sync;
  end
`endif

  // Edge sources and the W1C mask, decoded in the current cycle.
  always_comb begin
    edge_set = (gpio_filt & ~filt_q & rise_en) | (~gpio_filt & filt_q & fall_en);
    w1c_mask = (wen && addr == PIC_GPIO_REG_STATUS) ? wdata : '0;
  end

  // Register read mux.
  always_comb begin
    // NOTE: assigning a default first means every path drives reg_val, so no latch is inferred.
    reg_val = '0;
    case (addr)
      PIC_GPIO_REG_FILT:    reg_val = gpio_filt;
      PIC_GPIO_REG_STATUS:  reg_val = status;
      PIC_GPIO_REG_RISE_EN: reg_val = rise_en;
      PIC_GPIO_REG_FALL_EN: reg_val = fall_en;
      default:              reg_val = '0;
    endcase
  end

  // Edge history, edge status (a new edge wins over a W1C clear), and the enable registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q  <= '0;
      status  <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else begin
      filt_q <= gpio_filt;
      status <= (status & ~w1c_mask) | edge_set;
      if (wen && addr == PIC_GPIO_REG_RISE_EN) rise_en <= wdata;
      if (wen && addr == PIC_GPIO_REG_FALL_EN) fall_en <= wdata;
    end
  end

  // Access acknowledge. The read data is sampled before any write in the same cycle takes effect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= wen | ren;
      rdata <= ren ? reg_val : '0;
    end
  end

  assign irq = |status;

endmodule

// File: tb/tb_pic_gpio_cond.sv
// tb_pic_gpio_cond: directed, self-checking bench for pic_gpio_cond with PRESCALE=4 and DEB_TICKS=3.
// Expected values follow whether PIC_GPIO_COND_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module tb_pic_gpio_cond;
  import pic_gpio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pin_in = '0;
  logic [15:0] gpio_filt;
  logic [1:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [15:0] rdata;
  logic        ready;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pic_gpio_cond #(.WIDTH(16), .PRESCALE(4), .DEB_TICKS(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pin_in    (pin_in),
    .gpio_filt (gpio_filt),
    .addr      (addr),
    .wdata     (wdata),
    .wen       (wen),
    .ren       (ren),
    .rdata     (rdata),
    .ready     (ready),
    .irq       (irq)
  );

  // Advance one clock cycle. Sampling and driving both happen 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one bus cycle and return what the DUT shows in the acknowledge cycle.
  task automatic bus(input logic [1:0] a, input logic [15:0] d, input logic w, input logic r,
                     output logic [15:0] rd, output logic rdy);
    addr = a; wdata = d; wen = w; ren = r;
    step();
    wen = 1'b0; ren = 1'b0;
    rd = rdata; rdy = ready;
  endtask

  // Wait until gpio_filt[0] reaches the given level, giving up after a bounded number of cycles.
  task automatic wait_bit0(input logic lvl, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (gpio_filt[0] === lvl) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic irq_seen;
    int   found;
    logic [15:0] rd;
    logic rdy;
    pin_in = 16'hAA55; reset_n = 1'b0;
    repeat (3) step();
    checks++;
    if (gpio_filt !== 16'h0 || rdata !== 16'h0 || ready !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: filt=%h rdata=%h ready=%b irq=%b, required all 0", gpio_filt, rdata, ready, irq);
    end
    reset_n = 1'b1;
    irq_seen = 1'b0;
`ifdef PIC_GPIO_COND_DEBOUNCE_EN
    found = -1;
    for (int k = 1; k <= 15; k++) begin
      step();
      irq_seen |= irq;
      if (gpio_filt === 16'hAA55) begin
        found = k;
        break;
      end
    end
    checks++;
    if (found < 0) begin
      failures++;
      $display("FAIL reset_release_filt: filt=%h after 15 cycles, required 16'haa55", gpio_filt);
    end
`else
    found = 0;
    step(); step(); irq_seen |= irq;
    checks++;
    if (gpio_filt !== 16'h0) begin
      failures++;
      $display("FAIL reset_release_early: filt=%h after 2 cycles, required 0", gpio_filt);
    end
    step(); irq_seen |= irq;
    checks++;
    if (gpio_filt !== 16'hAA55) begin
      failures++;
      $display("FAIL reset_release_filt: filt=%h after 3 cycles, required 16'haa55", gpio_filt);
    end
`endif
    // Return all pins low and let them settle. No enables are set, so no status bit may appear.
    pin_in = 16'h0;
    repeat (20) begin
      step();
      irq_seen |= irq;
    end
    checks++;
    if (irq_seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq_quiet: irq seen=%b, required 0", irq_seen);
    end
    bus(PIC_GPIO_REG_STATUS, 16'h0, 1'b0, 1'b1, rd, rdy);
    checks++;
    if (rdy !== 1'b1 || rd !== 16'h0) begin
      failures++;
      $display("FAIL reset_status: ready=%b status=%h, required 1/0000", rdy, rd);
    end
  endtask

  task automatic test_glitch();
    logic seen;
    logic [15:0] rd;
    logic rdy;
    seen = 1'b0;
    for (int i = 0; i < 26; i++) begin
      pin_in[0] = (i < 6);
      step();
      seen |= gpio_filt[0];
    end
    checks++;
`ifdef PIC_GPIO_COND_DEBOUNCE_EN
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL glitch_reject: filt[0] seen=%b, required 0", seen);
    end
`else
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL glitch_pass: filt[0] seen=%b, required 1", seen);
    end
`endif
    bus(PIC_GPIO_REG_STATUS, 16'h0, 1'b0, 1'b1, rd, rdy);
    checks++;
    if (rd !== 16'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL glitch_status: status=%h irq=%b, required 0/0", rd, irq);
    end
  endtask

  task automatic test_registers();
    logic [15:0] rd;
    logic rdy;
    bus(PIC_GPIO_REG_FILT, 16'hFFFF, 1'b1, 1'b0, rd, rdy);
    checks++;
    if (rdy !== 1'b1 || rd !== 16'h0) begin
      failures++;
      $display("FAIL write_ack: ready=%b rdata=%h, required 1/0000", rdy, rd);
    end
    bus(PIC_GPIO_REG_FILT, 16'h0, 1'b0, 1'b1, rd, rdy);
    checks++;
    if (rd !== 16'h0) begin
      failures++;
      $display("FAIL filt_read_only: rdata=%h, required 0000", rd);
    end
    bus(PIC_GPIO_REG_RISE_EN, 16'h0001, 1'b1, 1'b0, rd, rdy);
    bus(PIC_GPIO_REG_FALL_EN, 16'h0001, 1'b1, 1'b0, rd, rdy);
    bus(PIC_GPIO_REG_RISE_EN, 16'h0, 1'b0, 1'b1, rd, rdy);
    checks++;
    if (rd !== 16'h0001) begin
      failures++;
      $display("FAIL rise_en_rb: rdata=%h, required 0001", rd);
    end
    bus(PIC_GPIO_REG_FALL_EN, 16'h0, 1'b0, 1'b1, rd, rdy);
    checks++;
    if (rd !== 16'h0001) begin
      failures++;
      $display("FAIL fall_en_rb: rdata=%h, required 0001", rd);
    end
  endtask

  task automatic test_stable_edge_w1c();
    int lat;
    logic [15:0] rd;
    logic rdy;
    pin_in[0] = 1'b1;
    wait_bit0(1'b1, lat);
    checks++;
    if (lat < 0 || lat > 15) begin
      failures++;
      $display("FAIL rise_latency: %0d cycles, required 1..15", lat);
    end
    step();
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL rise_irq: irq=%b, required 1", irq);
    end
    bus(PIC_GPIO_REG_STATUS, 16'h0, 1'b0, 1'b1, rd, rdy);
    checks++;
    if (rd !== 16'h0001) begin
      failures++;
      $display("FAIL rise_status: status=%h, required 0001", rd);
    end
    bus(PIC_GPIO_REG_STATUS, 16'h0001, 1'b1, 1'b0, rd, rdy);
    checks++;
    if (rdy !== 1'b1 || irq !== 1'b0) begin
      failures++;
      $display("FAIL w1c_clear: ready=%b irq=%b, required 1/0", rdy, irq);
    end
    bus(PIC_GPIO_REG_STATUS, 16'h0, 1'b0, 1'b1, rd, rdy);
    checks++;
    if (rd !== 16'h0) begin
      failures++;
      $display("FAIL w1c_status: status=%h, required 0000", rd);
    end
    pin_in[0] = 1'b0;
    wait_bit0(1'b0, lat);
    step();
    checks++;
    if (lat < 0 || irq !== 1'b1) begin
      failures++;
      $display("FAIL fall_edge: latency=%0d irq=%b, required irq 1", lat, irq);
    end
    bus(PIC_GPIO_REG_STATUS, 16'h0000, 1'b1, 1'b0, rd, rdy);
    bus(PIC_GPIO_REG_STATUS, 16'h0, 1'b0, 1'b1, rd, rdy);
    checks++;
    if (rd !== 16'h0001) begin
      failures++;
      $display("FAIL w1c_zero_noop: status=%h, required 0001", rd);
    end
    bus(PIC_GPIO_REG_STATUS, 16'h0001, 1'b1, 1'b0, rd, rdy);
  endtask

  task automatic test_collisions();
    int lat;
    logic [15:0] rd;
    logic rdy;
    // A rising edge and a W1C of the same bit in the same cycle: the new edge must win.
    pin_in[0] = 1'b1;
    wait_bit0(1'b1, lat);
    bus(PIC_GPIO_REG_STATUS, 16'h0001, 1'b1, 1'b0, rd, rdy);
    bus(PIC_GPIO_REG_STATUS, 16'h0, 1'b0, 1'b1, rd, rdy);
    checks++;
    if (lat < 0 || rd !== 16'h0001 || irq !== 1'b1) begin
      failures++;
      $display("FAIL clear_set_collision: latency=%0d status=%h irq=%b, required 0001/1", lat, rd, irq);
    end
    bus(PIC_GPIO_REG_STATUS, 16'h0001, 1'b1, 1'b0, rd, rdy);
    // fall_en is cleared in the same cycle as a falling edge; the old enable still applies to that edge.
    pin_in[0] = 1'b0;
    wait_bit0(1'b0, lat);
    bus(PIC_GPIO_REG_FALL_EN, 16'h0000, 1'b1, 1'b0, rd, rdy);
    bus(PIC_GPIO_REG_STATUS, 16'h0, 1'b0, 1'b1, rd, rdy);
    checks++;
    if (lat < 0 || rd !== 16'h0001) begin
      failures++;
      $display("FAIL enable_edge_collision: latency=%0d status=%h, required 0001", lat, rd);
    end
    bus(PIC_GPIO_REG_STATUS, 16'hFFFF, 1'b1, 1'b0, rd, rdy);
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd;
    logic rdy;
    // Bit 0 of 16'h5a3c stays low, and rise_en only covers bit 0, so no status bit is set.
    pin_in = 16'h5A3C;
    repeat (20) step();
    addr = PIC_GPIO_REG_FILT; ren = 1'b1;
    step();
    checks++;
    if (ready !== 1'b1 || rdata !== 16'h5A3C) begin
      failures++;
      $display("FAIL b2b_first: ready=%b rdata=%h, required 1/5a3c", ready, rdata);
    end
    step();
    ren = 1'b0;
    checks++;
    if (ready !== 1'b1 || rdata !== 16'h5A3C) begin
      failures++;
      $display("FAIL b2b_second: ready=%b rdata=%h, required 1/5a3c", ready, rdata);
    end
    step();
    checks++;
    if (ready !== 1'b0 || rdata !== 16'h0) begin
      failures++;
      $display("FAIL b2b_idle: ready=%b rdata=%h, required 0/0000", ready, rdata);
    end
    // A write and a read in the same cycle return the value from before the write.
    bus(PIC_GPIO_REG_RISE_EN, 16'h00F0, 1'b1, 1'b1, rd, rdy);
    checks++;
    if (rdy !== 1'b1 || rd !== 16'h0001) begin
      failures++;
      $display("FAIL rw_prewrite: ready=%b rdata=%h, required 1/0001", rdy, rd);
    end
    bus(PIC_GPIO_REG_RISE_EN, 16'h0, 1'b0, 1'b1, rd, rdy);
    checks++;
    if (rd !== 16'h00F0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL rw_postwrite: rdata=%h irq=%b, required 00f0/0", rd, irq);
    end
    // Assert reset asynchronously while the acknowledge is high.
    addr = PIC_GPIO_REG_FILT; ren = 1'b1;
    step();
    ren = 1'b0;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: ready=%b, required 1", ready);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || rdata !== 16'h0 || gpio_filt !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_access: ready=%b rdata=%h filt=%h, required 0/0000/0000", ready, rdata, gpio_filt);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    step();
    test_reset();
    test_glitch();
    test_registers();
    test_stable_edge_w1c();
    test_collisions();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_gpio_cond.md
# pic_gpio_cond

Input conditioner for the PIC core's 16-bit GPIO input bus. It sits between the badge pins and `pic_wrapper.gpio_in`. It synchronises each raw pin into `clk`, optionally debounces it, and presents a clean registered word to the PIC. It also detects rising and falling edges per bit, latches them into a status register, and raises an interrupt, all through a small register port on the SoC side.

## Interface
Parameters:
- `WIDTH`, 16: number of GPIO bits.
- `PRESCALE`, 1000: `clk` cycles per debounce tick; range 2..65535.
- `DEB_TICKS`, 4: consecutive stable ticks required before the filtered bit changes; range 1..15.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `pin_in` in WIDTH: raw, asynchronous pin levels.
- `gpio_filt` out WIDTH: conditioned level; drives `pic_wrapper.gpio_in`.
- `addr` in 2: register select.
- `wdata` in WIDTH: write data.
- `wen` in 1: write strobe; one-cycle pulse.
- `ren` in 1: read strobe; one-cycle pulse.
- `rdata` out WIDTH: read data; valid while `ready` is high.
- `ready` out 1: access acknowledge.
- `irq` out 1: level interrupt, equal to |status.

## Operation
Input path:
- 2-FF synchroniser per bit produces `sync`.
- The filter compares `sync` against `gpio_filt` and drives `gpio_filt`.

Debounce (compiled in):
- A shared prescaler counts 0..PRESCALE-1 and pulses `tick` on wrap.
- Each bit has a 4-bit counter `cnt[i]`.
  - If `sync[i]==gpio_filt[i]`: `cnt[i]` is cleared on every cycle.
  - Else on `tick`: `cnt[i]++`.
  - When the increment reaches DEB_TICKS: `gpio_filt[i]` takes `sync[i]` and `cnt[i]` is cleared.
- A bit that bounces back before reaching DEB_TICKS never changes `gpio_filt`.

Edge detection:
- `rise = gpio_filt & ~filt_q`, `fall = ~gpio_filt & filt_q`, where `filt_q` is `gpio_filt` delayed 1 cycle.
- `status |= (rise & rise_en) | (fall & fall_en)`.

Registers:
- 0 `gpio_filt`: RO; writes ignored.
- 1 `status`: W1C.
- 2 `rise_en`: RW.
- 3 `fall_en`: RW.

Access handshake:
- `wen` or `ren` is sampled at edge N, and `ready` is high for exactly cycle N+1.
- Read: `rdata` is registered and valid during that cycle; `rdata` is 0 whenever `ready` is low.
- `wen` and `ren` asserted together: the write is performed and `rdata` returns the pre-write value.
- A strobe arriving while `ready` is high is accepted normally, so back-to-back accesses run at one per cycle.

Boundary rules:
- A W1C clear and a new edge on the same bit in the same cycle: set wins.
- Write-enable and edge in the same cycle: the new enable applies from the next cycle.

## Timing
Reset values (`reset_n` low, asynchronous):
- Synchroniser FFs, `gpio_filt`, `filt_q`: 0.
- `cnt`, prescaler: 0.
- `status`, `rise_en`, `fall_en`: 0.
- `rdata`, `ready`, `irq`: 0.
- With enables reset to 0, a pin held high across reset sets no status.

Latency:
- Pin change to `gpio_filt`, debounce out: 3 cycles (2 sync + 1 filter register).
- Pin change to `gpio_filt`, debounce in: between (DEB_TICKS−1)·PRESCALE+3 and DEB_TICKS·PRESCALE+3 cycles.
- `gpio_filt` change to `status` bit: 1 cycle.
- `status` to `irq`: combinational.

Reset mid-operation:
- In-flight debounce counts are discarded and any pending `ready` pulse is dropped.

## Configuration
- `PIC_GPIO_COND_DEBOUNCE_EN` defined: prescaler and per-bit counters are present, behaving as above.
- Undefined: no prescaler or counters are built. `gpio_filt <= sync` every cycle, and `PRESCALE`/`DEB_TICKS` are ignored.
- Register map and handshake are identical in both builds.

## Structure
- Shared package `pic_gpio_pkg`:
  - register address constants `PIC_GPIO_REG_FILT/STATUS/RISE_EN/FALL_EN` (0..3).
  - counter width constant (4).
- Sub-module `pic_gpio_sync2`: 2-FF synchroniser, WIDTH-parameterised, with async active-low reset.
- Everything else lives in the top module.

## Test plan
Benches run with PRESCALE=4 and DEB_TICKS=3 unless stated otherwise.

1. Reset: hold `reset_n`=0 with `pin_in`=16'hAA55, then release. Required: all outputs 0. Debounce out: `gpio_filt`=16'hAA55 on the 3rd cycle after release. Debounce in: `gpio_filt`=16'hAA55 within 15 cycles of release. `irq` stays 0 throughout.
2. Glitch rejection (debounce in): pulse bit 0 high for 6 cycles, then low. Required: `gpio_filt[0]` stays 0 and `status` stays 0.
3. Stable edge (debounce in): write `rise_en`=16'h0001 and `fall_en`=16'h0001, then drive bit 0 high for 20 cycles. Required: `gpio_filt[0]` rises within 15 cycles, `status`=16'h0001 one cycle later, `irq`=1. Driving bit 0 low again sets the fall edge the same way.
4. W1C: write `status` with 16'h0001. Required: `ready` high on the next cycle, after which `status`=0 and `irq`=0. Writing 16'h0000 leaves `status` unchanged.
5. Clear/set collision: write `status` W1C bit 0 in the same cycle a rising edge on bit 0 is detected. Required: `status[0]`=1 afterwards.
6. Read handshake: issue `ren` with `addr`=0 on back-to-back cycles. Required: `ready` high on 2 consecutive cycles, each with `rdata`=`gpio_filt`. Asynchronous reset asserted mid-access: `ready` drops to 0 immediately.
